// File: rtl/mips_isa_pkg.sv
// MIPS instruction-set constants and a small operand decoder shared by the issue front end.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [4:0]  LINK_REG = 5'd31;

  typedef struct packed {
    logic       src1_v;
    logic [4:0] src1;
    logic       src2_v;
    logic [4:0] src2;
    logic       dst_v;
    logic [4:0] dst;
    logic       is_ctrl;
  } decode_t;

  // Register operands and control-transfer flag; unknown opcodes touch no registers.
  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[OP_MSB:OP_LSB];
    fn = instr[FN_MSB:FN_LSB];
    d = '0;
    d.src1 = instr[RS_MSB:RS_LSB];
    d.src2 = instr[RT_MSB:RT_LSB];
    case (op)
      OP_RTYPE: begin
        d.src1_v = 1'b1;
        if (fn == FN_JR) begin
          d.is_ctrl = 1'b1;
        end else begin
          d.src2_v = 1'b1;
          d.dst_v  = 1'b1;
          d.dst    = instr[RD_MSB:RD_LSB];
        end
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW: begin
        d.src1_v = 1'b1;
        d.dst_v  = 1'b1;
        d.dst    = instr[RT_MSB:RT_LSB];
      end
      OP_SW: begin
        d.src1_v = 1'b1;
        d.src2_v = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.src1_v  = 1'b1;
        d.src2_v  = 1'b1;
        d.is_ctrl = 1'b1;
      end
      OP_J: begin
        d.is_ctrl = 1'b1;
      end
      OP_JAL: begin
        d.dst_v   = 1'b1;
        d.dst     = LINK_REG;
        d.is_ctrl = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with push, pop, flush and occupancy count.
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Flush wins over both ports so nothing survives the flush edge.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hazard_issue_unit.sv
// Issue front end: buffers instructions and inserts NOPs only for RAW or control hazards,
// using a per-register writeback countdown scoreboard and a control-bubble counter.
module hazard_issue_unit
  import mips_isa_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int WB_LAT       = 4,
  parameter int CTRL_BUBBLES = 3,
  parameter int NREG         = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [31:0]                       in_instr,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [31:0]                       i_datain,
  output logic                              issue_valid,
  output logic                              stall,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int SBW = (WB_LAT > 0) ? $clog2(WB_LAT+1) : 1;
  localparam int CCW = (CTRL_BUBBLES > 0) ? $clog2(CTRL_BUBBLES+1) : 1;

  logic [31:0]    w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_hazard;
  logic           w_block;
  logic           w_issue;
  logic           w_dst_load;
  decode_t        w_dec;

  logic [SBW-1:0] r_sb [NREG];
  logic [CCW-1:0] r_cc;
  logic [31:0]    r_datain;
  logic           r_issue_valid;
  logic           r_stall;

  assign in_ready = !w_full && !flush;
  assign w_push   = in_valid && in_ready;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (in_instr),
    .i_pop   (w_issue),
    .i_flush (flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign w_dec = decode(w_head);

  // gr0 is hard-wired, so it can neither create nor suffer a RAW hazard.
  assign w_hazard = (w_dec.src1_v && (w_dec.src1 != 5'd0) && (r_sb[w_dec.src1] != '0)) ||
                    (w_dec.src2_v && (w_dec.src2 != 5'd0) && (r_sb[w_dec.src2] != '0));
  assign w_block    = (r_cc != '0) || w_hazard;
  assign w_issue    = !flush && !w_empty && !w_block;
  assign w_dst_load = w_issue && w_dec.dst_v && (w_dec.dst != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      always_ff @(posedge clock) begin
        if (reset) begin
          r_sb[gi] <= '0;
        end else if (w_dst_load && (w_dec.dst == 5'(gi))) begin
          r_sb[gi] <= SBW'(WB_LAT);
        end else if (r_sb[gi] != '0) begin
          r_sb[gi] <= r_sb[gi] - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_cc <= '0;
    end else if (w_issue && w_dec.is_ctrl) begin
      r_cc <= CCW'(CTRL_BUBBLES);
    end else if (r_cc != '0) begin
      r_cc <= r_cc - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_datain      <= NOP_WORD;
      r_issue_valid <= 1'b0;
      r_stall       <= 1'b0;
    end else if (w_issue) begin
      r_datain      <= w_head;
      r_issue_valid <= 1'b1;
      r_stall       <= 1'b0;
    end else begin
      r_datain      <= NOP_WORD;
      r_issue_valid <= 1'b0;
      r_stall       <= !flush && !w_empty && w_block;
    end
  end

  assign i_datain    = r_datain;
  assign issue_valid = r_issue_valid;
  assign stall       = r_stall;

endmodule

// File: tb/tb_hazard_issue_unit.sv
// Directed bench for hazard_issue_unit with hand-computed issue timelines.
module tb_hazard_issue_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [31:0] i_datain;
  logic        issue_valid;
  logic        stall;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  hazard_issue_unit #(
    .FIFO_DEPTH   (8),
    .WB_LAT       (4),
    .CTRL_BUBBLES (3),
    .NREG         (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .i_datain    (i_datain),
    .issue_valid (issue_valid),
    .stall       (stall),
    .count       (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [63:0] ex(logic v, logic s, logic [31:0] d);
    return {30'd0, v, s, d};
  endfunction

  function automatic logic [63:0] obs();
    return {30'd0, issue_valid, stall, i_datain};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  // Push a then b back-to-back; a issues, n_stall NOP cycles follow, then b issues.
  task automatic run_pair(string tag, logic [31:0] a, logic [31:0] b, int n_stall);
    do_reset();
    in_valid = 1'b1;
    in_instr = a;
    tick();
    check($sformatf("%s.nobypass", tag), obs(), ex(1'b0, 1'b0, 32'h0));
    check($sformatf("%s.count_e0", tag), 64'(count), 64'd1);
    in_instr = b;
    tick();
    in_valid = 1'b0;
    check($sformatf("%s.first", tag), obs(), ex(1'b1, 1'b0, a));
    check($sformatf("%s.count_pushpop", tag), 64'(count), 64'd1);
    for (int k = 0; k < n_stall; k++) begin
      tick();
      check($sformatf("%s.stall%0d", tag, k), obs(), ex(1'b0, 1'b1, 32'h0));
    end
    tick();
    check($sformatf("%s.second", tag), obs(), ex(1'b1, 1'b0, b));
    tick();
    check($sformatf("%s.drained", tag), obs(), ex(1'b0, 1'b0, 32'h0));
    check($sformatf("%s.count_end", tag), 64'(count), 64'd0);
    $display("pair %s: a=%h b=%h expected_stalls=%0d", tag, a, b, n_stall);
  endtask

  logic [31:0] words [11];
  logic [31:0] w_tmp;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    flush    = 1'b0;

    do_reset();
    check("reset.outputs", obs(), ex(1'b0, 1'b0, 32'h0));
    check("reset.count", 64'(count), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);

    run_pair("lw_add",   itype(6'b100011, 0, 1, 16'd1), rtype(1, 2, 3, 6'b100000), 4);
    run_pair("lw_sw_rt", itype(6'b100011, 0, 1, 16'd0), itype(6'b101011, 0, 1, 16'd4), 4);
    run_pair("lw_jr",    itype(6'b100011, 0, 1, 16'd0), rtype(1, 0, 0, 6'b001000), 4);
    run_pair("ori_add",  itype(6'b001101, 0, 4, 16'd7), rtype(4, 0, 5, 6'b100000), 4);
    run_pair("addiu_rt", itype(6'b001001, 0, 7, 16'd1), rtype(0, 7, 8, 6'b100000), 4);
    run_pair("andi_add", itype(6'b001100, 0, 9, 16'd3), rtype(9, 0, 10, 6'b100000), 4);
    run_pair("indep",    itype(6'b001000, 0, 1, 16'd1), itype(6'b001000, 0, 2, 16'd2), 0);
    run_pair("unk_op",   itype(6'b100011, 0, 1, 16'd0), itype(6'b111111, 1, 1, 16'd0), 0);
    run_pair("j_addi",   jtype(6'b000010, 26'h3FFF), itype(6'b001000, 0, 1, 16'd5), 3);
    run_pair("jal_r31",  jtype(6'b000011, 26'h100), itype(6'b001000, 31, 5, 16'd1), 4);
    run_pair("beq_addi", itype(6'b000100, 0, 0, 16'd2), itype(6'b001000, 0, 1, 16'd1), 3);
    run_pair("bne_addi", itype(6'b000101, 0, 0, 16'd2), itype(6'b001000, 0, 1, 16'd1), 3);
    run_pair("jr_addi",  rtype(0, 0, 0, 6'b001000), itype(6'b001000, 0, 1, 16'd1), 3);
    run_pair("reg0",     rtype(1, 2, 0, 6'b100000), rtype(0, 0, 3, 6'b100000), 0);
    run_pair("nop_word", 32'h0000_0000, itype(6'b001000, 0, 2, 16'd9), 0);

    // Fill: two dependent adds hold the head long enough for the FIFO to fill.
    do_reset();
    words[0] = itype(6'b100011, 0, 20, 16'd0);
    words[1] = rtype(20, 0, 21, 6'b100000);
    words[2] = rtype(21, 0, 22, 6'b100000);
    for (int k = 1; k <= 8; k++) words[k+2] = itype(6'b001000, 0, k, 16'(k));
    in_valid = 1'b1;
    for (int p = 0; p < 10; p++) begin
      in_instr = words[p];
      tick();
    end
    check("full.count", 64'(count), 64'd8);
    check("full.in_ready", 64'(in_ready), 64'd0);
    in_instr = words[10];
    tick();
    check("full.refused_count", 64'(count), 64'd8);
    check("full.stall", obs(), ex(1'b0, 1'b1, 32'h0));
    check("full.in_ready_hold", 64'(in_ready), 64'd0);
    tick();
    check("full.pop_no_push", 64'(count), 64'd7);
    check("full.issue_z", obs(), ex(1'b1, 1'b0, words[2]));
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("stream.addi%0d", k), obs(), ex(1'b1, 1'b0, words[k+2]));
    end
    tick();
    check("stream.drained", obs(), ex(1'b0, 1'b0, 32'h0));
    check("stream.count", 64'(count), 64'd0);
    $display("fill: 8 queued, push refused while full, 8 issued in stream");

    // Reset mid-stream with sb[1] at 3 and queued consumers.
    do_reset();
    in_valid = 1'b1;
    in_instr = itype(6'b001000, 0, 1, 16'd1);
    tick();
    in_instr = rtype(1, 1, 2, 6'b100000);
    tick();
    tick();
    check("midrst.pre_count", 64'(count), 64'd2);
    check("midrst.pre_stall", obs(), ex(1'b0, 1'b1, 32'h0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.count", 64'(count), 64'd0);
    check("midrst.outputs", obs(), ex(1'b0, 1'b0, 32'h0));
    w_tmp = rtype(1, 1, 4, 6'b100000);
    in_instr = w_tmp;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst.sb_cleared", obs(), ex(1'b1, 1'b0, w_tmp));
    $display("reset mid-stream: queue and scoreboard discarded");

    // Flush right after jal: cc cleared, sb[31] keeps counting down.
    do_reset();
    in_valid = 1'b1;
    in_instr = jtype(6'b000011, 26'h100);
    w_tmp = in_instr;
    tick();
    in_instr = itype(6'b001000, 0, 11, 16'd1);
    tick();
    check("flush.jal_issue", obs(), ex(1'b1, 1'b0, w_tmp));
    flush = 1'b1;
    in_instr = itype(6'b001000, 0, 12, 16'd1);
    #1;
    check("flush.in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush.count", 64'(count), 64'd0);
    check("flush.no_issue", obs(), ex(1'b0, 1'b0, 32'h0));
    in_instr = itype(6'b001000, 0, 6, 16'd1);
    w_tmp = in_instr;
    tick();
    check("flush.refill_count", 64'(count), 64'd1);
    check("flush.refill_nobypass", obs(), ex(1'b0, 1'b0, 32'h0));
    in_instr = itype(6'b001000, 31, 5, 16'd1);
    tick();
    in_valid = 1'b0;
    check("flush.cc_cleared", obs(), ex(1'b1, 1'b0, w_tmp));
    w_tmp = itype(6'b001000, 31, 5, 16'd1);
    tick();
    check("flush.sb_kept", obs(), ex(1'b0, 1'b1, 32'h0));
    tick();
    check("flush.r31_issue", obs(), ex(1'b1, 1'b0, w_tmp));
    tick();
    check("flush.drained", 64'(count), 64'd0);
    $display("flush: queue and control counter cleared, scoreboard retained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
